// File: rtl/conv_tree_deserializer.sv
// conv_tree_deserializer
// Serial-to-parallel receiver for framed words from the conv tree serializer.
// A frame begins on a valid bit qualified by FRAME_START and completes after
// OUTPUTS_NUM valid bits. A FRAME_START inside a frame restarts it. A stall of
// TIMEOUT idle cycles aborts it. Both cases pulse FRAME_ERR.
//
// Ports:
//   CLK          in   rising-edge clock
//   RESET        in   synchronous active-high reset
//   SERIAL_IN    in   serial data bit
//   SERIAL_VALID in   qualifies SERIAL_IN
//   FRAME_START  in   current valid bit is bit 0 of a word
//   PAR_OUT      out  last completed word, held until the next completes
//   PAR_VALID    out  one-cycle pulse when PAR_OUT updates
//   BUSY         out  a frame is partially received
//   FRAME_ERR    out  one-cycle pulse when a partial frame is discarded
module conv_tree_deserializer #(
  parameter int unsigned OUTPUTS_NUM = 16,
  parameter bit          LSB_FIRST   = 1'b0,
  parameter int unsigned TIMEOUT     = 32
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   SERIAL_IN,
  input  logic                   SERIAL_VALID,
  input  logic                   FRAME_START,
  output logic [OUTPUTS_NUM-1:0] PAR_OUT,
  output logic                   PAR_VALID,
  output logic                   BUSY,
  output logic                   FRAME_ERR
);

  localparam int unsigned CNT_W  = $clog2(OUTPUTS_NUM) + 1;
  localparam int unsigned IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]             state_q,     state_d;
  logic [OUTPUTS_NUM-1:0] shreg_q,     shreg_d;
  logic [CNT_W-1:0]       cnt_q,       cnt_d;
  logic [IDLE_W-1:0]      idle_q,      idle_d;
  logic [OUTPUTS_NUM-1:0] par_out_q,   par_out_d;
  logic                   par_valid_q, par_valid_d;
  logic                   frame_err_q, frame_err_d;

  logic [OUTPUTS_NUM-1:0] start_word;
  logic [OUTPUTS_NUM-1:0] shift_word;

  // Word seeded with the first bit, and the shift register advanced by one bit.
  // Both orders shift so the first bit ends at its final position after
  // OUTPUTS_NUM bits without indexing by the bit count.
  always_comb begin
    start_word = '0;
    if (LSB_FIRST) begin
      start_word[OUTPUTS_NUM-1] = SERIAL_IN;
      shift_word = {SERIAL_IN, shreg_q[OUTPUTS_NUM-1:1]};
    end else begin
      start_word[0] = SERIAL_IN;
      shift_word = {shreg_q[OUTPUTS_NUM-2:0], SERIAL_IN};
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    idle_d      = idle_q;
    par_out_d   = par_out_q;
    par_valid_d = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Valid bits without FRAME_START are dropped silently here.
        if (SERIAL_VALID && FRAME_START) begin
          shreg_d = start_word;
          cnt_d   = CNT_W'(1);
          idle_d  = '0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (SERIAL_VALID) begin
          idle_d = '0;
          if (FRAME_START) begin
            // Restart takes priority, even over a would-be final bit.
            frame_err_d = 1'b1;
            shreg_d     = start_word;
            cnt_d       = CNT_W'(1);
          end else if (cnt_q == CNT_W'(OUTPUTS_NUM - 1)) begin
            par_out_d   = shift_word;
            par_valid_d = 1'b1;
            shreg_d     = '0;
            cnt_d       = '0;
            state_d     = ST_IDLE;
          end else begin
            shreg_d = shift_word;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end else if (TIMEOUT != 0) begin
          // Abort on the stall cycle that would bring the counter to TIMEOUT.
          if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
            frame_err_d = 1'b1;
            shreg_d     = '0;
            cnt_d       = '0;
            idle_d      = '0;
            state_d     = ST_IDLE;
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        shreg_d = '0;
        cnt_d   = '0;
        idle_d  = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      idle_q      <= '0;
      par_out_q   <= '0;
      par_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      idle_q      <= idle_d;
      par_out_q   <= par_out_d;
      par_valid_q <= par_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign PAR_OUT   = par_out_q;
  assign PAR_VALID = par_valid_q;
  assign FRAME_ERR = frame_err_q;
  assign BUSY      = (state_q == ST_SHIFT);

endmodule

// File: doc/conv_tree_deserializer.md
# conv_tree_deserializer

Serial-to-parallel receiver that reassembles framed words produced by the conv tree serializer back into `OUTPUTS_NUM`-bit parallel words. It sits at the receive end of the serial link and feeds downstream parallel logic with a registered word plus a one-cycle valid strobe. Framing is explicit through `FRAME_START`. Malformed or stalled frames are flagged and discarded.

## Interface
- `OUTPUTS_NUM`, default 16: word width; power of two, at least 2.
- `LSB_FIRST`, default 0: 0 = first serial bit lands in `PAR_OUT[OUTPUTS_NUM-1]`; 1 = first bit lands in `PAR_OUT[0]`.
- `TIMEOUT`, default 32: number of consecutive idle cycles inside a frame before it is aborted; 0 disables the timeout.

- `CLK`  in  1  clock; all logic on the rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `SERIAL_IN`  in  1  serial data bit.
- `SERIAL_VALID`  in  1  qualifies `SERIAL_IN` this cycle.
- `FRAME_START`  in  1  marks the current valid bit as bit 0 of a word; ignored unless `SERIAL_VALID`=1.
- `PAR_OUT`  out  `OUTPUTS_NUM`  last completed word; held until the next word completes.
- `PAR_VALID`  out  1  one-cycle pulse; `PAR_OUT` just updated.
- `BUSY`  out  1  high while a frame is partially received (state SHIFT).
- `FRAME_ERR`  out  1  one-cycle pulse; a partial frame was discarded.

## Operation
- State IDLE:
  - `SERIAL_VALID` & `FRAME_START`: store the bit as the first bit, set bit count to 1, go to SHIFT.
  - `SERIAL_VALID` without `FRAME_START`: ignored; no error.
- State SHIFT: every valid bit without `FRAME_START` is stored at the next position and increments the bit count.
  - The bit count has width `$clog2(OUTPUTS_NUM)+1`.
  - Bit position follows `LSB_FIRST`.
  - Word ordering: with `LSB_FIRST`=0 the shift register shifts left and the new bit enters at bit 0.
- Completion: on the edge that accepts bit number `OUTPUTS_NUM`, `PAR_OUT` loads the full word, `PAR_VALID`=1 for the next cycle, and the state returns to IDLE.
  - A `FRAME_START` on the very next cycle is accepted, so back-to-back words run with zero bubble.
- Restart: `SERIAL_VALID` & `FRAME_START` while in SHIFT:
  - `FRAME_ERR` pulses and the partial word is discarded; `PAR_OUT` is unchanged.
  - That same bit becomes bit 0 of a new frame, with the count set to 1; the state stays SHIFT.
  - `FRAME_START` wins even when this would otherwise have been the final bit.
- Stall: cycles with `SERIAL_VALID`=0 in SHIFT leave the data and bit count unchanged and increment the idle counter.
  - Any valid bit clears the idle counter.
  - When the idle counter reaches `TIMEOUT` (`TIMEOUT`>0): `FRAME_ERR` pulses, the partial word is discarded, and the state returns to IDLE.
  - If a valid bit arrives on the cycle the counter would reach `TIMEOUT`, the valid bit wins and no error is raised.
- `OUTPUTS_NUM`=2 edge case: completion happens on the second accepted bit; SHIFT is occupied for exactly one accepted bit.

## Timing
- Reset values: `PAR_OUT`=0, `PAR_VALID`=0, `BUSY`=0, `FRAME_ERR`=0; state IDLE; bit count and idle counter 0.
- Reset mid-frame: the partial word is dropped with no `PAR_VALID` and no `FRAME_ERR`; `PAR_OUT` returns to 0.
- Latency: `PAR_VALID` is high in the cycle immediately after the edge that samples the last bit.
  - With a continuous stream, `PAR_VALID` arrives `OUTPUTS_NUM` cycles after the cycle in which `FRAME_START` was sampled.
- `BUSY` is registered:
  - high from the cycle after the first bit is accepted;
  - low in the same cycle that `PAR_VALID` or a timeout `FRAME_ERR` is high;
  - stays high across a restart.
- `PAR_VALID` and `FRAME_ERR` are never high in the same cycle.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
- Continuous stream, N=16, `LSB_FIRST`=0: word 16'hC5AF sent MSB-first with `FRAME_START` on the first bit -> `PAR_OUT`=16'hC5AF; `PAR_VALID` high for exactly one cycle, 16 cycles after start; `BUSY` high for 15 cycles.
- Back-to-back words 16'hC5AF then 16'h0001, no gap -> two `PAR_VALID` pulses 16 cycles apart; `PAR_OUT` holds C5AF until 0001 loads.
- Stalls and timeout:
  - Insert 5-cycle `SERIAL_VALID`=0 gaps after bits 3 and 9 of 16'hA5A5 -> `PAR_OUT`=16'hA5A5, `PAR_VALID` delayed by 10 cycles, no `FRAME_ERR`.
  - Then stop after 7 bits with `TIMEOUT`=32 -> `FRAME_ERR` pulses 32 cycles after the last bit; `BUSY` drops; `PAR_OUT` stays 16'hA5A5.
- Restart: `FRAME_START` on bit 10 of a frame, followed by 16 bits of 16'h1234 -> `FRAME_ERR` pulse the cycle after the restart bit; then `PAR_OUT`=16'h1234.
- `LSB_FIRST`=1, N=8: bits 1,1,1,1,0,1,0,1 in order -> `PAR_OUT`=8'hAF. Also send valid bits with no `FRAME_START` in IDLE -> no outputs change.
- Reset: assert `RESET` for one cycle after bit 12 of a frame -> all outputs 0; no `PAR_VALID`; a fresh frame 16'hFFFF afterwards decodes correctly.
